// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad scanner: FSM states, key-code map, one-hot decoding.
package keypad_pkg;

    typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_e;

    // Indexed by {row_idx, col_idx}; row 0 is the top keypad row.
    localparam logic [3:0] KeyMap [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs, synchronous active-high reset.
module sync_2ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad column scanner with press/release debounce; emits one key_valid pulse per press.
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       int_osc,
    input  logic       rst,
    input  logic [3:0] row_d,
    output logic [3:0] column_signals,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int unsigned DwellW = $clog2(SCAN_DIV);
    localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DwellW-1:0] DwellLast = DwellW'(SCAN_DIV - 1);
    localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

    logic [3:0] row_s;

    sync_2ff #(
        .Width (4)
    ) u_row_sync (
        .clk_i (int_osc),
        .rst_i (rst),
        .d_i   (row_d),
        .q_o   (row_s)
    );

    state_e            state_q, state_d;
    logic [DwellW-1:0] dwell_q, dwell_d;
    logic [DbW-1:0]    db_q, db_d;
    logic [3:0]        col_q, col_d;
    logic [3:0]        row_lat_q, row_lat_d;
    logic              valid_q, valid_d;
    logic [3:0]        code_q, code_d;
    logic              held_q, held_d;
    logic [3:0]        col_next;

    assign col_next = {col_q[2:0], col_q[3]};

    always_comb begin
        state_d   = state_q;
        dwell_d   = dwell_q;
        db_d      = db_q;
        col_d     = col_q;
        row_lat_d = row_lat_q;
        valid_d   = 1'b0;
        code_d    = code_q;
        held_d    = held_q;

        unique case (state_q)
            SCAN: begin
                // Rows are only looked at on the last dwell cycle, after settle and sync latency.
                if (dwell_q == DwellLast) begin
                    dwell_d = '0;
                    if (is_onehot(row_s)) begin
                        row_lat_d = row_s;
                        db_d      = '0;
                        state_d   = PRESS_DB;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            PRESS_DB: begin
                if (row_s != row_lat_q) begin
                    col_d   = col_next;
                    dwell_d = '0;
                    state_d = SCAN;
                end else if (db_q == DbLast) begin
                    valid_d = 1'b1;
                    code_d  = KeyMap[{onehot_to_idx(row_lat_q), onehot_to_idx(col_q)}];
                    held_d  = 1'b1;
                    db_d    = '0;
                    state_d = HELD;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            HELD: begin
                if (row_s != row_lat_q) begin
                    db_d    = '0;
                    state_d = REL_DB;
                end
            end
            REL_DB: begin
                if (row_s == row_lat_q) begin
                    state_d = HELD;
                end else if (db_q == DbLast) begin
                    held_d  = 1'b0;
                    col_d   = col_next;
                    dwell_d = '0;
                    db_d    = '0;
                    state_d = SCAN;
                end else begin
                    db_d = db_q + 1'b1;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    always_ff @(posedge int_osc) begin
        if (rst) begin
            state_q   <= SCAN;
            dwell_q   <= '0;
            db_q      <= '0;
            col_q     <= 4'b0001;
            row_lat_q <= 4'b0000;
            valid_q   <= 1'b0;
            code_q    <= 4'h0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dwell_q   <= dwell_d;
            db_q      <= db_d;
            col_q     <= col_d;
            row_lat_q <= row_lat_d;
            valid_q   <= valid_d;
            code_q    <= code_d;
            held_q    <= held_d;
        end
    end

    assign column_signals = col_q;
    assign key_valid      = valid_q;
    assign key_code       = code_q;
    assign key_held       = held_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Directed bench for keypad_scan_debounce with SCAN_DIV=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scan_debounce;

    logic       int_osc;
    logic       rst;
    logic [3:0] row_d;
    logic [3:0] column_signals;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;

    keypad_scan_debounce #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .int_osc        (int_osc),
        .rst            (rst),
        .row_d          (row_d),
        .column_signals (column_signals),
        .key_valid      (key_valid),
        .key_code       (key_code),
        .key_held       (key_held)
    );

    typedef struct {
        logic       rst;
        logic [3:0] row;
        logic [3:0] col;
        logic       valid;
        logic       held;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[20];
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   pulses;
    int   pulse_cyc;
    logic [3:0] pulse_code;

    initial begin
        int_osc = 1'b0;
        forever #5 int_osc = ~int_osc;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach its end (got hang, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are observed 1 time unit after each rising edge.
    task automatic step();
        @(posedge int_osc);
        #1;
        cyc++;
        if (key_valid === 1'b1) begin
            pulses++;
            pulse_cyc  = cyc;
            pulse_code = key_code;
        end
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        row_d = 4'b0000;
        step();
        step();
        rst       = 1'b0;
        cyc       = 0;
        pulses    = 0;
        pulse_cyc = -1;
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] c);
        vec_t v;
        v.rst   = r;
        v.row   = 4'b0000;
        v.col   = c;
        v.valid = 1'b0;
        v.held  = 1'b0;
        v.code  = 4'h0;
        return v;
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cyc       = 0;
        pulses    = 0;
        pulse_cyc = -1;
        rst       = 1'b1;
        row_d     = 4'b0000;

        // Reset for 3 cycles, then free scanning: one column step every 4 cycles.
        vecs[0]  = mk(1'b1, 4'b0001); vecs[1]  = mk(1'b1, 4'b0001);
        vecs[2]  = mk(1'b1, 4'b0001); vecs[3]  = mk(1'b0, 4'b0001);
        vecs[4]  = mk(1'b0, 4'b0001); vecs[5]  = mk(1'b0, 4'b0001);
        vecs[6]  = mk(1'b0, 4'b0010); vecs[7]  = mk(1'b0, 4'b0010);
        vecs[8]  = mk(1'b0, 4'b0010); vecs[9]  = mk(1'b0, 4'b0010);
        vecs[10] = mk(1'b0, 4'b0100); vecs[11] = mk(1'b0, 4'b0100);
        vecs[12] = mk(1'b0, 4'b0100); vecs[13] = mk(1'b0, 4'b0100);
        vecs[14] = mk(1'b0, 4'b1000); vecs[15] = mk(1'b0, 4'b1000);
        vecs[16] = mk(1'b0, 4'b1000); vecs[17] = mk(1'b0, 4'b1000);
        vecs[18] = mk(1'b0, 4'b0001); vecs[19] = mk(1'b0, 4'b0001);

        for (int i = 0; i < 20; i++) begin
            rst   = vecs[i].rst;
            row_d = vecs[i].row;
            step();
            check($sformatf("vec%0d_col", i), 32'(column_signals), 32'(vecs[i].col));
            check($sformatf("vec%0d_valid", i), 32'(key_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_held", i), 32'(key_held), 32'(vecs[i].held));
            check($sformatf("vec%0d_code", i), 32'(key_code), 32'(vecs[i].code));
        end

        // Clean press of '2': row0 while column 1 is driven; dwell end at cycle 8.
        reset_dut();
        step_to(4);
        row_d = 4'b0001;
        step_to(15);
        check("press_no_early_pulse", 32'(pulses), 32'd0);
        check("press_held_before", 32'(key_held), 32'd0);
        step_to(16);
        check("press_valid", 32'(key_valid), 32'd1);
        check("press_code", 32'(key_code), 32'h2);
        check("press_held", 32'(key_held), 32'd1);
        step_to(17);
        check("press_valid_single", 32'(key_valid), 32'd0);
        step_to(24);
        check("press_pulse_count", 32'(pulses), 32'd1);
        check("press_pulse_cycle", 32'(pulse_cyc), 32'd16);
        check("press_col_frozen", 32'(column_signals), 32'b0010);
        row_d = 4'b0000;
        step_to(34);
        check("release_held_pending", 32'(key_held), 32'd1);
        step_to(35);
        check("release_held_clear", 32'(key_held), 32'd0);
        check("release_col_next", 32'(column_signals), 32'b0100);
        check("release_no_pulse", 32'(pulses), 32'd1);

        // Press bounce: row2 seen for 3 cycles at column 0, then gone.
        reset_dut();
        step_to(1);
        row_d = 4'b0100;
        step_to(4);
        row_d = 4'b0000;
        check("pbounce_col_latched", 32'(column_signals), 32'b0001);
        step_to(6);
        check("pbounce_col_frozen", 32'(column_signals), 32'b0001);
        step_to(7);
        check("pbounce_abort_col", 32'(column_signals), 32'b0010);
        step_to(11);
        check("pbounce_rescan_col", 32'(column_signals), 32'b0100);
        step_to(30);
        check("pbounce_no_pulse", 32'(pulses), 32'd0);

        // Release bounce on '5', then a new press aborted by reset mid-debounce.
        reset_dut();
        step_to(4);
        row_d = 4'b0010;
        step_to(24);
        check("rbounce_pulse_cycle", 32'(pulse_cyc), 32'd16);
        check("rbounce_code", 32'(pulse_code), 32'h5);
        row_d = 4'b0000;
        step_to(28);
        row_d = 4'b0010;
        step_to(30);
        check("rbounce_held_in_bounce", 32'(key_held), 32'd1);
        step_to(40);
        check("rbounce_held_after", 32'(key_held), 32'd1);
        check("rbounce_one_pulse", 32'(pulses), 32'd1);
        row_d = 4'b0000;
        step_to(50);
        check("rbounce_rel_pending", 32'(key_held), 32'd1);
        step_to(51);
        check("rbounce_released", 32'(key_held), 32'd0);
        check("rbounce_col_next", 32'(column_signals), 32'b0100);
        check("rbounce_code_kept", 32'(key_code), 32'h5);
        row_d = 4'b0100;
        step_to(60);
        check("midrst_col_frozen", 32'(column_signals), 32'b0100);
        check("midrst_no_pulse_yet", 32'(pulses), 32'd1);
        rst   = 1'b1;
        row_d = 4'b0000;
        step();
        check("midrst_col", 32'(column_signals), 32'b0001);
        check("midrst_valid", 32'(key_valid), 32'd0);
        check("midrst_code", 32'(key_code), 32'h0);
        check("midrst_held", 32'(key_held), 32'd0);
        rst = 1'b0;
        step_to(85);
        check("midrst_discarded", 32'(pulses), 32'd1);

        // Two rows at once is not a key: scanning continues undisturbed.
        reset_dut();
        row_d = 4'b0101;
        step_to(4);
        check("multi_col_rotates", 32'(column_signals), 32'b0010);
        step_to(40);
        check("multi_col_wraps", 32'(column_signals), 32'b0100);
        check("multi_no_pulse", 32'(pulses), 32'd0);
        check("multi_not_held", 32'(key_held), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan_debounce.md
Name: keypad_scan_debounce

Overview:
- Upstream stage of the keypad-to-display path.
- Drives the 4x4 keypad columns one-hot and samples the asynchronous row inputs through a synchronizer.
- Debounces both press and release.
- Emits exactly one single-cycle key_valid pulse with a 4-bit hex key code per physical press. The downstream digit-shift/display-mux stage consumes the pulse and code.

Parameters:
- SCAN_DIV, 1000, int_osc cycles each column is driven (dwell); legal minimum 4.
- DEBOUNCE_CYCLES, 20000, consecutive stable cycles required to accept a press or a release; legal minimum 2.

Ports:
- int_osc  input  1  system clock
- rst  input  1  synchronous active-high reset
- row_d  input  4  raw asynchronous keypad rows, active-high
- column_signals  output  4  one-hot active-high column drive
- key_valid  output  1  single-cycle pulse on an accepted new press
- key_code  output  4  hex code of the last accepted key; held between pulses
- key_held  output  1  high from the key_valid cycle until the release is accepted

Behaviour:
- Clock and reset: one clock, int_osc. rst is synchronous, active-high.
- Reset values: column_signals=4'b0001, key_valid=0, key_code=4'h0, key_held=0, state=SCAN, all counters 0, synchronizer flops 0.
- Row synchronizer: row_d passes through 2 flops to give row_s. FSM logic uses only row_s.
- Valid row: row_s is exactly one-hot. Zero rows or multiple rows set counts as "no key".
- SCAN:
  - dwell counter runs 0..SCAN_DIV-1.
  - At count SCAN_DIV-1: if row_s is valid, latch row_s and the column index, clear the debounce counter, go to PRESS_DB. Otherwise rotate the column (0001->0010->0100->1000->0001) and restart the dwell.
  - Rows are never evaluated before the dwell end (covers settle and synchronizer latency).
- PRESS_DB:
  - column frozen.
  - Each cycle, row_s must equal the latched row. A mismatch returns to SCAN at the next column with no pulse.
  - After DEBOUNCE_CYCLES matching cycles: key_valid=1 for exactly one cycle, key_code is updated in that same cycle, key_held=1, go to HELD.
- Latency: dwell-end cycle T leads to key_valid high in cycle T+DEBOUNCE_CYCLES+1.
- HELD:
  - column frozen, no pulses.
  - Any cycle with row_s != latched row: clear the counter, go to REL_DB.
- REL_DB:
  - Needs DEBOUNCE_CYCLES consecutive cycles with row_s != latched row.
  - If the latched row reappears: back to HELD with no new pulse (bounce on release).
  - On completion: key_held=0, rotate to the next column, go to SCAN.
- Second key pressed while one is held is ignored; no pulse for it.
- Key map, code by (row, col):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E,0,F,D
- Reset mid-operation (any state) returns to the reset values on the next edge. A pending press is discarded with no pulse.
- Counter widths are $clog2 of the parameter. Counters never wrap past their terminal value.

Decomposition:
- Package keypad_pkg holds:
  - state enum typedef {SCAN, PRESS_DB, HELD, REL_DB}
  - 16-entry key-code lookup constant indexed {row_idx, col_idx}
  - one-hot-to-index function
- Sub-module sync_2ff (parameterized width) implements the row synchronizer.
- FSM and counters stay in the top module.

Test Plan (SCAN_DIV=4, DEBOUNCE_CYCLES=8):
- Reset: hold rst 3 cycles -> column_signals=0001, key_valid=0, key_code=0, key_held=0. Release rst -> columns rotate every 4 cycles, wrapping 1000->0001.
- Clean press: row_d=0001 held while column 0010 is driven -> exactly one key_valid pulse 9 cycles after dwell end, key_code=4'h2, key_held=1. Release for 8+ cycles -> key_held=0, column moves to 0100.
- Press bounce: row_d=0100 for 3 cycles, then 0000 -> no pulse, scanning resumes at the next column.
- Release bounce: held key '5' (row 0001 -> r1? use row_d=0010, col 0010), drop row for 4 cycles then restore, hold, then release cleanly -> single pulse total with key_code=4'h5.
- Multi-row: row_d=0101 at dwell end -> treated as no key, no pulse, columns keep rotating.
- Reset mid-PRESS_DB: assert rst 5 cycles into debounce -> no pulse, outputs return to reset values.
